// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector: loadable 1..MAX_LEN bit pattern,
// overlap/non-overlap matching, registered match pulse and saturating match counter.
module seq_detector_prog #(
    parameter int                 MAX_LEN = 8,
    parameter int                 LEN_W   = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = {MAX_LEN{1'b1}},
    parameter int                 DEF_LEN = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data,
    input  logic               valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt
);

    // Stream contract: data is consumed on every edge where valid=1 and
    // pat_load=0; there is no ready/backpressure, the detector always accepts.

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   len_clamped;
    logic               match;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    always_comb begin
        len_clamped = len_in;
        if (len_in == '0) begin
            len_clamped = LEN_W'(1);
        end else if (len_in > MAX_LEN_L) begin
            len_clamped = MAX_LEN_L;
        end
    end

    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        len_d    = len_q;
        match    = 1'b0;
        fill_inc = (fill_q >= MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);

        if (pat_load) begin
            // A load restarts the search; the bit presented this cycle is dropped.
            pat_d  = pat_in;
            len_d  = len_clamped;
            hist_d = '0;
            fill_d = '0;
        end else if (valid) begin
            hist_d = {hist_q[MAX_LEN-2:0], data};
            fill_d = fill_inc;
            match  = (fill_inc >= len_q) && (((hist_d ^ pat_q) & len_mask) == '0);
            if (match && !overlap) begin
                fill_d = '0;
            end
        end

        out_d = match;

        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PAT;
            len_q  <= DEF_LEN_L;
            out_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog; a second instance with a 2-bit counter
// exercises saturation on the same stimulus.
module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       data;
    logic       valid;
    logic       overlap;
    logic       pat_load;
    logic [7:0] pat_in;
    logic [3:0] len_in;
    logic       cnt_clr;
    logic       out;
    logic [7:0] match_cnt;
    logic       out2;
    logic [1:0] match_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_detector_prog dut (
        .clk(clk), .reset(reset), .data(data), .valid(valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
        .out(out), .match_cnt(match_cnt)
    );

    seq_detector_prog #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .data(data), .valid(valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
        .out(out2), .match_cnt(match_cnt2)
    );

    // Drive one cycle, then settle just past the rising edge for sampling.
    task automatic step(input logic d, input logic v);
        data  = d;
        valid = v;
        @(posedge clk);
        #1;
        data  = 1'b0;
        valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l);
        pat_load = 1'b1;
        pat_in   = p;
        len_in   = l;
        step(1'b0, 1'b0);
        pat_load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got %b want 0", out);
        end
        n_checks++;
        if (match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", match_cnt);
        end
    endtask

    // stream 1,1,1,1,0,1,1,1 (MSB first) against default "111"
    task automatic test_default_stream(input logic ov, input logic [7:0] exp_out,
                                       input logic [7:0] exp_cnt);
        logic [7:0] bits;
        bits = 8'b1111_0111;
        do_reset();
        overlap = ov;
        for (int i = 7; i >= 0; i--) begin
            step(bits[i], 1'b1);
            n_checks++;
            if (out !== exp_out[i]) begin
                n_fail++;
                $display("FAIL default_ov%0b_bit%0d: out=%b want %b", ov, 8 - i, out, exp_out[i]);
            end
        end
        n_checks++;
        if (match_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL default_ov%0b_cnt: got %0d want %0d", ov, match_cnt, exp_cnt);
        end
    endtask

    // pattern 1011 len 4, stream 1,0,1,1,0,1,1
    task automatic test_pattern_1011(input logic ov, input logic [6:0] exp_out);
        logic [6:0] bits;
        bits = 7'b1011011;
        overlap = ov;
        load(8'b0000_1011, 4'd4);
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL p1011_load_out: got %b want 0", out);
        end
        for (int i = 6; i >= 0; i--) begin
            step(bits[i], 1'b1);
            n_checks++;
            if (out !== exp_out[i]) begin
                n_fail++;
                $display("FAIL p1011_ov%0b_bit%0d: out=%b want %b", ov, 7 - i, out, exp_out[i]);
            end
        end
    endtask

    task automatic test_gaps_and_load_discard();
        logic [4:0] bits;
        logic [4:0] exp_out;
        overlap = 1'b1;
        load(8'b0000_0101, 4'd3);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (out !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_out_%0d: got %b want 0", i, out);
            end
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_partial: got %b want 0", out);
        end
        step(1'b1, 1'b1);
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_match: got %b want 1", out);
        end
        // load with valid=1 and data=1: that bit must not count
        pat_load = 1'b1;
        pat_in   = 8'b0000_0101;
        len_in   = 4'd3;
        step(1'b1, 1'b1);
        pat_load = 1'b0;
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL load_valid_out: got %b want 0", out);
        end
        bits    = 5'b01101;
        exp_out = 5'b00001;
        for (int i = 4; i >= 0; i--) begin
            step(bits[i], 1'b1);
            n_checks++;
            if (out !== exp_out[i]) begin
                n_fail++;
                $display("FAIL load_discard_bit%0d: out=%b want %b", 5 - i, out, exp_out[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_big [5];
        logic [1:0] exp_small [5];
        exp_big   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        exp_small = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        overlap = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int m = 0; m < 5; m++) begin
            step(1'b1, 1'b1);
            n_checks++;
            if (out2 !== 1'b1 || match_cnt2 !== exp_small[m]) begin
                n_fail++;
                $display("FAIL sat_small_%0d: out=%b cnt=%0d want out=1 cnt=%0d",
                         m, out2, match_cnt2, exp_small[m]);
            end
            n_checks++;
            if (match_cnt !== exp_big[m]) begin
                n_fail++;
                $display("FAIL sat_big_%0d: cnt=%0d want %0d", m, match_cnt, exp_big[m]);
            end
        end
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        n_checks++;
        if (match_cnt !== 8'd1 || match_cnt2 !== 2'd1) begin
            n_fail++;
            $display("FAIL clr_with_match: cnt=%0d cnt2=%0d want 1 1", match_cnt, match_cnt2);
        end
        cnt_clr = 1'b1;
        step(1'b1, 1'b0);
        cnt_clr = 1'b0;
        n_checks++;
        if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL clr_alone: cnt=%0d cnt2=%0d want 0 0", match_cnt, match_cnt2);
        end
    endtask

    task automatic test_reset_midstream_and_len_clamp();
        logic [2:0] exp3;
        logic [3:0] bits4;
        logic [7:0] bits8;
        overlap = 1'b1;
        load(8'b0000_0000, 4'd2);
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got %b want 0", out);
        end
        exp3 = 3'b001;
        for (int i = 2; i >= 0; i--) begin
            step(1'b1, 1'b1);
            n_checks++;
            if (out !== exp3[i]) begin
                n_fail++;
                $display("FAIL post_reset_bit%0d: out=%b want %b", 3 - i, out, exp3[i]);
            end
        end
        load(8'h01, 4'd0);
        bits4 = 4'b1101;
        for (int i = 3; i >= 0; i--) begin
            step(bits4[i], 1'b1);
            n_checks++;
            if (out !== bits4[i]) begin
                n_fail++;
                $display("FAIL len0_bit%0d: out=%b want %b", 4 - i, out, bits4[i]);
            end
        end
        load(8'hA5, 4'd15);
        bits8 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            step(bits8[i], 1'b1);
            n_checks++;
            if (out !== (i == 0)) begin
                n_fail++;
                $display("FAIL len15_bit%0d: out=%b want %b", 8 - i, out, (i == 0));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        data     = 1'b0;
        valid    = 1'b0;
        overlap  = 1'b1;
        pat_load = 1'b0;
        pat_in   = 8'h00;
        len_in   = 4'd0;
        cnt_clr  = 1'b0;
        test_reset();
        test_default_stream(1'b1, 8'b0011_0001, 8'd3);
        test_default_stream(1'b0, 8'b0010_0001, 8'd2);
        test_pattern_1011(1'b1, 7'b0001001);
        test_pattern_1011(1'b0, 7'b0001000);
        test_gaps_and_load_discard();
        test_saturation();
        test_reset_midstream_and_len_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
